// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer: per-stage register enables, bubbles and IF/ID flush.
// Latency: outputs are combinational from registered state plus ID-stage hazard inputs.
// Backpressure: freezes upstream stages on RAW hazard, mult/div occupancy and halt.
// Optional statistics counters are built only when STALL_STATS_EN is defined.
module pipeline_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned STAT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_hazard_id,
  input  logic              redirect_id,
  input  logic              md_start_ex,
  input  logic              halt_syscall_wb,
  input  logic              resume,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              if_id_flush,
  output logic              halted,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_MD_WAIT = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  // A single-cycle mult/div never needs the wait state.
  localparam bit         MD_MULTI  = (MD_LATENCY > 1);
  // The first EX cycle happens in RUN, so the wait state covers LATENCY-1 cycles.
  localparam logic [3:0] MD_RELOAD = MD_MULTI ? 4'(MD_LATENCY - 2) : 4'd0;

  state_t     state_q, state_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  // State and occupancy counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      md_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Next-state logic: halt overrides everything, including a fresh mult/div start.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    if (halt_syscall_wb) begin
      state_d  = S_HALT;
      md_cnt_d = 4'd0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (md_start_ex && MD_MULTI) begin
            state_d  = S_MD_WAIT;
            md_cnt_d = MD_RELOAD;
          end
        end
        S_MD_WAIT: begin
          if (md_cnt_q == 4'd0) begin
            state_d = S_RUN;
          end else begin
            md_cnt_d = md_cnt_q - 4'd1;
          end
        end
        S_HALT: begin
          if (resume) begin
            state_d = S_RUN;
          end
        end
        default: begin
          state_d  = S_RUN;
          md_cnt_d = 4'd0;
        end
      endcase
    end
  end

  // Output decode: same-cycle response so a hazard stalls in the cycle it is seen.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    if_id_flush   = 1'b0;
    halted        = 1'b0;
    case (state_q)
      S_RUN: begin
        if (raw_hazard_id) begin
          // Branch operands are stale under a RAW hazard, so any redirect waits.
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
        end else if (redirect_id) begin
          if_id_flush = 1'b1;
        end
      end
      S_MD_WAIT: begin
        // Everything up to EX is frozen; MEM/WB keep draining older work.
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        ex_mem_bubble = 1'b1;
      end
      S_HALT: begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        halted    = 1'b1;
      end
      default: begin
        pc_en = 1'b1;
      end
    endcase
  end

`ifdef STALL_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [STAT_W-1:0] stall_q, stall_d;
  logic [STAT_W-1:0] flush_q, flush_d;

  // Saturating increments; halted cycles are not counted as stalls.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && (state_q != S_HALT) && (stall_q != STAT_MAX)) begin
      stall_d = stall_q + STAT_W'(1);
    end
    if (if_id_flush && (flush_q != STAT_MAX)) begin
      flush_d = flush_q + STAT_W'(1);
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
